level_ctrl: RTL and testbench

- Produces the 4-bit level word that feeds the thermometer output decoder.
- The decoder turns that word into the 15-LED bar.
- Takes two raw pushbuttons (up/down), synchronises and debounces them, and keeps a saturating 0..15 level.
- Optional auto-decay lowers the level by one step after a fixed idle time.

---
 rtl/level_pkg.sv | 39 +++
 rtl/level_ctrl_if.sv | 23 ++
 rtl/btn_debounce.sv | 64 ++++++
 rtl/level_ctrl.sv | 114 +++++++++++
 tb/tb_level_ctrl.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/level_pkg.sv
// Shared types and constants for the level controller: level width, ceiling,
// FSM state encoding and debounce/decay timing defaults for sim and board.
package level_pkg;

  localparam int LEVEL_W = 4;
  localparam logic [LEVEL_W-1:0] LEVEL_MAX = 4'd15;

  localparam int DB_CYCLES_SIM      = 4;
  localparam int DB_CYCLES_BOARD    = 1_000_000;
  localparam int DECAY_CYCLES_SIM   = 16;
  localparam int DECAY_CYCLES_BOARD = 50_000_000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DEC  = 2'd2
  } state_e;

  function automatic logic [LEVEL_W-1:0] sat_inc(input logic [LEVEL_W-1:0] v);
    logic [LEVEL_W-1:0] r;
    if (v == LEVEL_MAX) begin
      r = v;
    end else begin
      r = v + LEVEL_W'(1);
    end
    return r;
  endfunction

  function automatic logic [LEVEL_W-1:0] sat_dec(input logic [LEVEL_W-1:0] v);
    logic [LEVEL_W-1:0] r;
    if (v == {LEVEL_W{1'b0}}) begin
      r = v;
    end else begin
      r = v - LEVEL_W'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/level_ctrl_if.sv
// Button/decay inputs and level outputs of the level controller, bundled
// so the driver side (master) and controller side (slave) share one port.
interface level_ctrl_if;
  import level_pkg::*;

  logic               btn_up;
  logic               btn_down;
  logic               decay_en;
  logic [LEVEL_W-1:0] level;
  logic               at_max;
  logic               at_min;
  logic               step_pulse;

  modport master (
    output btn_up, btn_down, decay_en,
    input  level, at_max, at_min, step_pulse
  );

  modport slave (
    input  btn_up, btn_down, decay_en,
    output level, at_max, at_min, step_pulse
  );
endinterface

// File: rtl/btn_debounce.sv
// Two-flop synchroniser, stability counter and registered one-cycle pulse
// on each debounced rising edge of a raw pushbutton.
module btn_debounce #(
  parameter int DB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic press
);

  localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             db_q, db_d;
  logic             db_dly_q, db_dly_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      db_q     <= 1'b0;
      db_dly_q <= 1'b0;
      press_q  <= 1'b0;
      cnt_q    <= {CNT_W{1'b0}};
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      db_q     <= db_d;
      db_dly_q <= db_dly_d;
      press_q  <= press_d;
      cnt_q    <= cnt_d;
    end
  end

  // The sample that makes DB_CYCLES consecutive disagreements flips the state.
  always_comb begin
    sync1_d  = btn_raw;
    sync2_d  = sync1_q;
    db_d     = db_q;
    cnt_d    = {CNT_W{1'b0}};
    if (sync2_q != db_q) begin
      if (cnt_q == CNT_LAST) begin
        db_d  = sync2_q;
        cnt_d = {CNT_W{1'b0}};
      end else begin
        db_d  = db_q;
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      db_d  = db_q;
      cnt_d = {CNT_W{1'b0}};
    end
    db_dly_d = db_q;
    press_d  = db_q & ~db_dly_q;
  end

  assign press = press_q;

endmodule

// File: rtl/level_ctrl.sv
// Saturating 0..LEVEL_MAX level driven by debounced up/down buttons, with an
// optional idle-time auto-decay FSM; feeds the thermometer output decoder.
module level_ctrl
  import level_pkg::*;
#(
  parameter int DB_CYCLES    = DB_CYCLES_SIM,
  parameter int DECAY_CYCLES = DECAY_CYCLES_SIM
) (
  input  logic        clk,
  input  logic        rst_n,
  level_ctrl_if.slave bus
);

  localparam int TMR_W = (DECAY_CYCLES > 1) ? $clog2(DECAY_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(DECAY_CYCLES - 1);

  logic               up_p;
  logic               down_p;
  logic               activity;
  state_e             state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic               step_q, step_d;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_up (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (bus.btn_up),
    .press   (up_p)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_down (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (bus.btn_down),
    .press   (down_p)
  );

  // Simultaneous and saturated presses still count as activity.
  assign activity = up_p | down_p;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      timer_q <= {TMR_W{1'b0}};
      level_q <= {LEVEL_W{1'b0}};
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      level_q <= level_d;
      step_q  <= step_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = {TMR_W{1'b0}};
    case (state_q)
      IDLE: begin
        if (bus.decay_en && (level_q != {LEVEL_W{1'b0}})) begin
          state_d = WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (activity) begin
          state_d = WAIT;
        end else if (!bus.decay_en || (level_q == {LEVEL_W{1'b0}})) begin
          state_d = IDLE;
        end else if (timer_q == TMR_LAST) begin
          state_d = DEC;
        end else begin
          state_d = WAIT;
          timer_d = timer_q + TMR_W'(1);
        end
      end
      DEC: begin
        if (activity || (level_d != {LEVEL_W{1'b0}})) begin
          state_d = WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // A press in the DEC cycle takes priority and the decay step is dropped.
  always_comb begin
    level_d = level_q;
    if (up_p && down_p) begin
      level_d = level_q;
    end else if (up_p) begin
      level_d = sat_inc(level_q);
    end else if (down_p) begin
      level_d = sat_dec(level_q);
    end else if (state_q == DEC) begin
      level_d = sat_dec(level_q);
    end else begin
      level_d = level_q;
    end
    step_d = (level_d != level_q);
  end

  assign bus.level      = level_q;
  assign bus.at_max     = (level_q == LEVEL_MAX);
  assign bus.at_min     = (level_q == {LEVEL_W{1'b0}});
  assign bus.step_pulse = step_q;

endmodule

// File: tb/tb_level_ctrl.sv
// Directed stimulus for level_ctrl; expected level steps are queued with the
// cycle they must appear on and a monitor checks every step_pulse against them.
module tb_level_ctrl;
  import level_pkg::*;

  typedef struct {
    int         cyc;
    logic [3:0] lvl;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   mark;
  logic [3:0] model = 4'd0;
  exp_t sb[$];

  level_ctrl_if bus();

  level_ctrl #(.DB_CYCLES(4), .DECAY_CYCLES(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_step(input int at, input logic [3:0] lvl);
    exp_t e;
    e.cyc = at;
    e.lvl = lvl;
    sb.push_back(e);
  endtask

  // A clean press: 10 cycles held, 10 released; raw edge lands just before edge 0.
  task automatic press(input bit up, input bit dn);
    if (up && !dn && model != 4'd15) begin
      model = model + 4'd1;
      expect_step(cyc + 8, model);
    end else if (dn && !up && model != 4'd0) begin
      model = model - 4'd1;
      expect_step(cyc + 8, model);
    end
    bus.btn_up   = up;
    bus.btn_down = dn;
    idle(10);
    bus.btn_up   = 1'b0;
    bus.btn_down = 1'b0;
    idle(10);
  endtask

  // Monitor: every step_pulse must match the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (sb.size() > 0 && cyc > sb[0].cyc) begin
          e = sb.pop_front();
          n_cmp++;
          n_bad++;
          $display("FAIL missed_step: no step_pulse, expected level %0d at cycle %0d", e.lvl, e.cyc);
        end
        if (bus.step_pulse) begin
          if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_step: got step_pulse with level %0d at cycle %0d, expected none",
                     bus.level, cyc);
          end else begin
            e = sb.pop_front();
            chk("step_cycle", cyc, e.cyc);
            chk("step_level", int'(bus.level), int'(e.lvl));
            chk("step_at_max", int'(bus.at_max), (e.lvl == 4'd15) ? 1 : 0);
            chk("step_at_min", int'(bus.at_min), (e.lvl == 4'd0) ? 1 : 0);
          end
        end
      end
    end
  end

  initial begin
    bus.btn_up   = 1'b0;
    bus.btn_down = 1'b0;
    bus.decay_en = 1'b0;
    rst_n        = 1'b0;
    idle(2);
    chk("reset_level", int'(bus.level), 0);
    chk("reset_at_min", int'(bus.at_min), 1);
    chk("reset_at_max", int'(bus.at_max), 0);
    chk("reset_step", int'(bus.step_pulse), 0);
    rst_n = 1'b1;
    idle(2);

    // Held button: one step to 1 on edge 7.
    bus.btn_up = 1'b1;
    model = 4'd1;
    expect_step(cyc + 8, 4'd1);
    idle(20);
    bus.btn_up = 1'b0;
    idle(10);
    chk("held_at_min", int'(bus.at_min), 0);

    // Glitches of 2 samples never survive debounce.
    repeat (3) begin
      bus.btn_up = 1'b1;
      idle(2);
      bus.btn_up = 1'b0;
      idle(2);
    end
    idle(15);
    chk("glitch_level", int'(bus.level), 1);

    // Fill to the ceiling, then a saturated press.
    repeat (14) press(1'b1, 1'b0);
    chk("full_level", int'(bus.level), 15);
    chk("full_at_max", int'(bus.at_max), 1);
    press(1'b1, 1'b0);
    chk("sat_up_level", int'(bus.level), 15);

    // Down to 3, then let decay run to 0 at 17-cycle intervals.
    repeat (12) press(1'b0, 1'b1);
    chk("down_level", int'(bus.level), 3);
    bus.decay_en = 1'b1;
    expect_step(cyc + 18, 4'd2);
    expect_step(cyc + 35, 4'd1);
    expect_step(cyc + 52, 4'd0);
    model = 4'd0;
    idle(90);
    chk("decay_level", int'(bus.level), 0);
    chk("decay_at_min", int'(bus.at_min), 1);
    chk("decay_fsm_idle", int'(dut.state_q), int'(IDLE));
    press(1'b0, 1'b1);
    chk("sat_down_level", int'(bus.level), 0);
    bus.decay_en = 1'b0;

    // Simultaneous press at 5 restarts the decay timer.
    repeat (5) press(1'b1, 1'b0);
    chk("five_level", int'(bus.level), 5);
    bus.decay_en = 1'b1;
    mark = cyc;
    idle(2);
    bus.btn_up   = 1'b1;
    bus.btn_down = 1'b1;
    model = 4'd4;
    expect_step(mark + 27, 4'd4);
    idle(10);
    bus.btn_up   = 1'b0;
    bus.btn_down = 1'b0;
    idle(mark + 27 - cyc);
    bus.decay_en = 1'b0;
    idle(20);
    chk("both_level", int'(bus.level), 4);

    // Reset mid-WAIT at 9 with up held: one press after release.
    repeat (5) press(1'b1, 1'b0);
    chk("nine_level", int'(bus.level), 9);
    bus.decay_en = 1'b1;
    idle(5);
    bus.btn_up = 1'b1;
    idle(2);
    rst_n = 1'b0;
    bus.decay_en = 1'b0;
    idle(1);
    chk("rst_mid_level", int'(bus.level), 0);
    chk("rst_mid_step", int'(bus.step_pulse), 0);
    chk("rst_mid_at_min", int'(bus.at_min), 1);
    rst_n = 1'b1;
    model = 4'd1;
    expect_step(cyc + 8, 4'd1);
    idle(20);
    bus.btn_up = 1'b0;
    idle(20);
    chk("after_rst_level", int'(bus.level), 1);

    chk("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
